// File: rtl/memory_responder_if.sv
// Memory-side bus between the CPU controller and memory_responder.
//   master : CPU controller (drives mem_read/mem_write/addr/wdata and the
//            program-load port, receives rdata/ack/busy/err/prog_ack)
//   slave  : memory_responder
// Signals:
//   mem_read, mem_write   single-cycle request strobes
//   mem_addr, mem_wdata   request address / write data (sampled on accept)
//   mem_rdata             registered read data
//   mem_ack               one-cycle completion pulse
//   mem_busy              access in progress, new requests ignored
//   mem_err               one-cycle pulse when read and write collide
//   prog_we/addr/data     program-load write port (honoured only when idle)
//   prog_ack              one-cycle pulse per program word written
interface memory_responder_if #(
  parameter int MEM_ADDR_SIZE = 6,
  parameter int WORD_SIZE     = 16
);
  logic                     mem_read;
  logic                     mem_write;
  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0]     mem_wdata;
  logic [WORD_SIZE-1:0]     mem_rdata;
  logic                     mem_ack;
  logic                     mem_busy;
  logic                     mem_err;
  logic                     prog_we;
  logic [MEM_ADDR_SIZE-1:0] prog_addr;
  logic [WORD_SIZE-1:0]     prog_data;
  logic                     prog_ack;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    output prog_we, prog_addr, prog_data,
    input  mem_rdata, mem_ack, mem_busy, mem_err, prog_ack
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  prog_we, prog_addr, prog_data,
    output mem_rdata, mem_ack, mem_busy, mem_err, prog_ack
  );
endinterface

// File: rtl/memory_responder.sv
// Memory-side endpoint of the CPU controller's memory interface.
// Word-addressed RAM; each accepted read/write completes WAIT_STATES+1
// cycles after acceptance with a one-cycle mem_ack. While idle, the
// program-load port can fill the RAM one word per cycle.
// Ports:
//   clock  system clock (rising edge)
//   reset  synchronous, active-high; aborts any access in flight,
//          RAM contents are preserved
//   bus    memory_responder_if.slave (request strobes, data, ack/busy/err,
//          program-load port)
module memory_responder #(
  parameter int INST_SIZE     = 6,
  parameter int REG_ADDR_SIZE = 4,
  parameter int MEM_ADDR_SIZE = 6,
  parameter int WORD_SIZE     = INST_SIZE + REG_ADDR_SIZE + MEM_ADDR_SIZE,
  parameter int WAIT_STATES   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  memory_responder_if.slave    bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [WORD_SIZE-1:0]     ram [2**MEM_ADDR_SIZE];

  logic [0:0]               state;
  logic [3:0]               wait_cnt;
  logic                     op_write;
  logic [MEM_ADDR_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]     wdata_q;
  logic [WORD_SIZE-1:0]     rdata_q;
  logic                     ack_q;
  logic                     err_q;
  logic                     prog_ack_q;

  logic req_one;
  logic req_both;
  logic prog_take;
  logic finish;

  // Exactly one strobe is a real request; both together is a protocol error.
  assign req_one   = bus.mem_read ^ bus.mem_write;
  assign req_both  = bus.mem_read & bus.mem_write;
  // Program load only when idle and the CPU is not asking for anything.
  assign prog_take = (state == IDLE) && !bus.mem_read && !bus.mem_write && bus.prog_we;
  assign finish    = (state == BUSY) && (wait_cnt == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      prog_ack_q <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      prog_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_one) begin
            op_write <= bus.mem_write;
            addr_q   <= bus.mem_addr;
            wdata_q  <= bus.mem_wdata;
            wait_cnt <= WAIT_LOAD;
            state    <= BUSY;
          end else if (req_both) begin
            err_q <= 1'b1;
          end else if (bus.prog_we) begin
            prog_ack_q <= 1'b1;
          end
        end
        default: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (!op_write) rdata_q <= ram[addr_q];
            ack_q <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // RAM is never cleared; reset only blocks a write from landing this edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (finish && op_write)
        ram[addr_q] <= wdata_q;
      else if (prog_take)
        ram[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ack   = ack_q;
  assign bus.mem_busy  = (state == BUSY);
  assign bus.mem_err   = err_q;
  assign bus.prog_ack  = prog_ack_q;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;
  localparam int WS = 2;
  localparam int K_ACK = 0, K_ERR = 1, K_PRG = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  memory_responder_if #(.MEM_ADDR_SIZE(6), .WORD_SIZE(16)) bus ();
  memory_responder_if #(.MEM_ADDR_SIZE(6), .WORD_SIZE(16)) bus0 ();

  memory_responder #(.WAIT_STATES(WS)) dut (.clock(clock), .reset(reset), .bus(bus));
  memory_responder #(.WAIT_STATES(0))  dut0 (.clock(clock), .reset(reset), .bus(bus0));

  // Reference model: RAM image, last completed read, busy window.
  logic [15:0] mem [64];
  logic [15:0] model_rdata = '0;
  int          busy_start  = 0;
  int          busy_until  = -10;
  bit          pend_wr     = 0;
  logic [5:0]  pend_addr;
  logic [15:0] pend_old;
  exp_t        q[$];
  bit          mon_en = 0;
  int          checks = 0;
  int          errors = 0;

  // Monitor: pops the scoreboard whenever an event is due.
  exp_t        e;
  logic        ea, ee, ep, eb;
  bit          has;
  always @(negedge clock) if (mon_en) begin
    ea = 0; ee = 0; ep = 0; has = 0;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_event kind=%0d due=%0d now=%0d", q[0].kind, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      has = 1;
      ea = (e.kind == K_ACK); ee = (e.kind == K_ERR); ep = (e.kind == K_PRG);
    end
    checks++;
    if ({bus.mem_ack, bus.mem_err, bus.prog_ack} !== {ea, ee, ep}) begin
      errors++;
      $display("FAIL pulses cyc=%0d ack/err/prog got=%b%b%b want=%b%b%b", cyc,
               bus.mem_ack, bus.mem_err, bus.prog_ack, ea, ee, ep);
    end
    eb = (cyc >= busy_start) && (cyc <= busy_until);
    checks++;
    if (bus.mem_busy !== eb) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.mem_busy, eb);
    end
    if (has) begin
      checks++;
      if (bus.mem_rdata !== e.rdata) begin
        errors++;
        $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, bus.mem_rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of stimulus at the current cycle k; model decides effect.
  task automatic issue(input logic rd, input logic wr, input logic [5:0] a,
                       input logic [15:0] wd, input logic pw,
                       input logic [5:0] pa, input logic [15:0] pd);
    int k = cyc;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_addr = a; bus.mem_wdata = wd;
    bus.prog_we = pw; bus.prog_addr = pa; bus.prog_data = pd;
    if (k > busy_until) begin
      if (rd && wr) begin
        q.push_back('{K_ERR, k + 1, model_rdata});
      end else if (rd || wr) begin
        busy_start = k + 1;
        busy_until = k + 1 + WS;
        pend_wr = wr;
        if (wr) begin
          pend_addr = a; pend_old = mem[a]; mem[a] = wd;
        end else begin
          model_rdata = mem[a];
        end
        q.push_back('{K_ACK, k + 2 + WS, model_rdata});
      end else if (pw) begin
        mem[pa] = pd;
        q.push_back('{K_PRG, k + 1, model_rdata});
      end
    end
    step();
    bus.mem_read = 0; bus.mem_write = 0; bus.prog_we = 0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_until) step();
  endtask

  task automatic do_reset();
    int k = cyc;
    reset = 1;
    if (k <= busy_until && pend_wr) mem[pend_addr] = pend_old;
    while (q.size() > 0 && q[$].cyc >= k + 1) void'(q.pop_back());
    model_rdata = '0;
    if (busy_until > k) busy_until = k;
    step();
    reset = 0;
    checks++;
    if (bus.mem_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h want=0000", bus.mem_rdata);
    end
  endtask

  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    bus0.mem_read = 0; bus0.mem_write = 0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
    bus0.prog_we = 0; bus0.prog_addr = '0; bus0.prog_data = '0;
    reset = 1;
    repeat (3) step();
    reset = 0;
    mon_en = 1;

    // Preload the whole RAM so the model image is fully known.
    for (int a = 0; a < 64; a++)
      issue(0, 0, 0, 0, 1, 6'(a), (a == 5) ? 16'h1234 : 16'($urandom));

    issue(1, 0, 5, 0, 0, 0, 0);                 // read 0x1234
    wait_idle();
    issue(0, 1, 63, 16'hBEEF, 0, 0, 0);         // write then read in ack cycle
    wait_idle();
    issue(1, 0, 63, 0, 0, 0, 0);
    wait_idle();
    issue(1, 1, 2, 16'h7777, 0, 0, 0);          // collision
    issue(1, 0, 2, 0, 0, 0, 0);
    wait_idle();
    issue(1, 0, 0, 0, 0, 0, 0);                 // busy: write+prog to 7 ignored
    issue(0, 1, 7, 16'hAAAA, 1, 7, 16'hAAAA);
    wait_idle();
    issue(1, 0, 7, 0, 0, 0, 0);
    wait_idle();
    issue(1, 0, 9, 0, 1, 9, 16'h0F0F);          // CPU wins over prog
    wait_idle();
    issue(1, 0, 9, 0, 0, 0, 0);
    wait_idle();
    issue(0, 1, 3, 16'h5555, 0, 0, 0);          // reset in second busy cycle
    step();
    do_reset();
    issue(1, 0, 3, 0, 0, 0, 0);
    wait_idle();

    // Randomised traffic, including requests while busy and rare resets.
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 11);
      logic [5:0]  a  = 6'($urandom);
      logic [15:0] d  = 16'($urandom);
      logic [5:0]  pa = 6'($urandom);
      if ($urandom_range(0, 79) == 0) do_reset();
      case (r)
        0, 1, 2: issue(1, 0, a, d, 0, pa, d);
        3, 4, 5: issue(0, 1, a, d, 0, pa, d);
        6:       issue(1, 1, a, d, 0, pa, d);
        7, 8:    issue(0, 0, a, d, 1, pa, d);
        9:       issue(1, 0, a, d, 1, pa, d ^ 16'hFFFF);
        10:      issue(0, 1, a, d, 1, a, d ^ 16'h00FF);
        default: issue(0, 0, a, d, 0, pa, d);
      endcase
    end
    wait_idle();
    repeat (4) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end

    // Zero-wait-state build: ack one cycle after acceptance.
    bus0.prog_we = 1; bus0.prog_addr = 10; bus0.prog_data = 16'hC3A5;
    step();
    bus0.prog_we = 0;
    bus0.mem_read = 1; bus0.mem_addr = 10;
    checks++;
    if (bus0.prog_ack !== 1'b1) begin
      errors++; $display("FAIL ws0_prog_ack got=%b want=1", bus0.prog_ack);
    end
    step();
    bus0.mem_read = 0;
    checks++;
    if ({bus0.mem_busy, bus0.mem_ack} !== 2'b10) begin
      errors++; $display("FAIL ws0_busy busy/ack got=%b%b want=10", bus0.mem_busy, bus0.mem_ack);
    end
    step();
    checks++;
    if ({bus0.mem_busy, bus0.mem_ack} !== 2'b01) begin
      errors++; $display("FAIL ws0_ack busy/ack got=%b%b want=01", bus0.mem_busy, bus0.mem_ack);
    end
    checks++;
    if (bus0.mem_rdata !== 16'hC3A5) begin
      errors++; $display("FAIL ws0_rdata got=%h want=c3a5", bus0.mem_rdata);
    end
    step();
    checks++;
    if (bus0.mem_ack !== 1'b0) begin
      errors++; $display("FAIL ws0_ack_pulse got=%b want=0", bus0.mem_ack);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
